// File: rtl/encoder8to3_seq.sv
// Sequential 8-to-3 request encoder: sticky pending set drained one index per valid/ready transfer.
// Define ENC8TO3_RR_EN to replace fixed (bit 7 highest) priority with round-robin selection.
module encoder8to3_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] Data_in,
  input  logic       ready,
  output logic [2:0] Data_out,
  output logic       valid,
  output logic [3:0] pend_cnt,
  output logic       dup
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] pending;
  logic [7:0] pending_next;
  logic [7:0] served;
  logic [7:0] arrive;
  logic [2:0] index;
  logic [2:0] index_next;
  logic [2:0] sel;
  logic [3:0] cnt_next;
  logic       dup_next;
  logic       xfer;
`ifdef ENC8TO3_RR_EN
  logic [2:0] pointer;
  logic [2:0] pointer_next;
`endif

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

`ifdef ENC8TO3_RR_EN
  // Closest set bit at or below start, wrapping 0 -> 7.
  function automatic logic [2:0] sel_rr(input logic [7:0] req, input logic [2:0] start);
    logic [2:0] res;
    logic [2:0] idx;
    res = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start - k[2:0];
      if (req[idx]) res = idx;
    end
    return res;
  endfunction
`else
  function automatic logic [2:0] sel_fixed(input logic [7:0] req);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) res = i[2:0];
    end
    return res;
  endfunction
`endif

  assign valid    = (state == PRESENT);
  assign Data_out = index;

  always_comb begin
    xfer          = (state == PRESENT) && ready;
    served        = 8'd0;
    if (xfer) served[index] = 1'b1;
    arrive        = en ? Data_in : 8'd0;
    // A bit served and re-requested on the same edge stays pending.
    pending_next  = (pending & ~served) | arrive;
    dup_next      = |(arrive & pending & ~served);
    cnt_next      = popcount(pending_next);
`ifdef ENC8TO3_RR_EN
    pointer_next  = xfer ? index : pointer;
    sel           = sel_rr(pending_next, pointer_next - 3'd1);
`else
    sel           = sel_fixed(pending_next);
`endif
    state_next    = state;
    index_next    = index;
    case (state)
      IDLE: begin
        if (pending_next != 8'd0) begin
          index_next = sel;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (pending_next != 8'd0) index_next = sel;
          else                      state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 8'd0;
      index    <= 3'd0;
      pend_cnt <= 4'd0;
      dup      <= 1'b0;
`ifdef ENC8TO3_RR_EN
      pointer  <= 3'd0;
`endif
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      index    <= index_next;
      pend_cnt <= cnt_next;
      dup      <= dup_next;
`ifdef ENC8TO3_RR_EN
      pointer  <= pointer_next;
`endif
    end
  end

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Scoreboard bench for encoder8to3_seq; expected indices are queued by the stimulus and
// consumed by a monitor on every valid/ready transfer.
module tb_encoder8to3_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] Data_in;
  logic       ready;
  logic [2:0] Data_out;
  logic       valid;
  logic [3:0] pend_cnt;
  logic       dup;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  encoder8to3_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .Data_in  (Data_in),
    .ready    (ready),
    .Data_out (Data_out),
    .valid    (valid),
    .pend_cnt (pend_cnt),
    .dup      (dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [7:0] d, input logic r);
    @(negedge clk);
    en      = e;
    Data_in = d;
    ready   = r;
  endtask

  // Inputs change only at the falling edge; sampling 2 time units later sees the
  // values the next rising edge will use.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL xfer_unexpected: got index %0d, expected no transfer", Data_out);
      end else begin
        check("xfer_index", int'(Data_out), exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    Data_in = 8'h00;
    ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", int'(Data_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_pend_cnt", int'(pend_cnt), 0);
    check("rst_dup", int'(dup), 0);
    rst_n = 1'b1;

    // Single request, consumer ready.
    exp_q.push_back(4);
    cyc(1'b1, 8'h10, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_valid", int'(valid), 1);
    check("t1_index", int'(Data_out), 4);
    check("t1_cnt", int'(pend_cnt), 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_valid_drop", int'(valid), 0);
    check("t1_cnt_zero", int'(pend_cnt), 0);

    // 8'hA5 held off by ready=0, then drained.
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
    cyc(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      check("t2_hold_index", int'(Data_out), 7);
      check("t2_hold_valid", int'(valid), 1);
      check("t2_hold_cnt", int'(pend_cnt), 4);
    end
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_index_b", int'(Data_out), 5);
    check("t2_cnt_b", int'(pend_cnt), 3);
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_index_c", int'(Data_out), 2);
    check("t2_cnt_c", int'(pend_cnt), 2);
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_index_d", int'(Data_out), 0);
    check("t2_cnt_d", int'(pend_cnt), 1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_valid_drop", int'(valid), 0);
    check("t2_cnt_zero", int'(pend_cnt), 0);

    // Capture disabled, then all eight back-to-back.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'hFF, 1'b1);
      check("t3_en0_valid", int'(valid), 0);
      check("t3_en0_cnt", int'(pend_cnt), 0);
    end
    for (int i = 7; i >= 0; i--) exp_q.push_back(i);
    cyc(1'b1, 8'hFF, 1'b1);
    for (int j = 0; j < 8; j++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("t3_b2b_index", int'(Data_out), 7 - j);
      check("t3_b2b_cnt", int'(pend_cnt), 8 - j);
      check("t3_b2b_valid", int'(valid), 1);
    end
    cyc(1'b0, 8'h00, 1'b0);
    check("t3_valid_drop", int'(valid), 0);
    check("t3_cnt_zero", int'(pend_cnt), 0);

    // Duplicate request on a pending bit.
    exp_q.push_back(3);
    cyc(1'b1, 8'h08, 1'b0);
    cyc(1'b1, 8'h08, 1'b0);
    check("t4_index", int'(Data_out), 3);
    check("t4_dup_first", int'(dup), 0);
    check("t4_cnt", int'(pend_cnt), 1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t4_dup_pulse", int'(dup), 1);
    check("t4_cnt_hold", int'(pend_cnt), 1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t4_dup_clear", int'(dup), 0);

    // Served and re-requested on the same edge: set wins.
    exp_q.push_back(3);
    cyc(1'b1, 8'h08, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("t5_valid", int'(valid), 1);
    check("t5_index", int'(Data_out), 3);
    check("t5_cnt", int'(pend_cnt), 1);
    check("t5_dup", int'(dup), 0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t5_valid_drop", int'(valid), 0);

    // Held 8'h81 with ready=1, then reset mid-stream.
    cyc(1'b1, 8'h81, 1'b1);
    for (int k = 0; k < 6; k++) begin
`ifdef ENC8TO3_RR_EN
      exp_q.push_back((k % 2 == 0) ? 7 : 0);
`else
      exp_q.push_back(7);
`endif
      cyc(1'b1, 8'h81, 1'b1);
      check("t6_cnt", int'(pend_cnt), 2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(valid), 0);
    check("t6_rst_cnt", int'(pend_cnt), 0);
    check("t6_rst_index", int'(Data_out), 0);
    repeat (2) @(negedge clk);
    en      = 1'b0;
    Data_in = 8'h00;
    ready   = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_valid", int'(valid), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
